// File: rtl/hex_scroll_pkg.sv
// Shared types and sizing helpers for hex_scroll_sequencer.
// HEX_SCROLL_LZB_EN (optional) enables leading-zero skipping in the top.
package hex_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Counter must hold the largest terminal count; never narrower than 1 bit.
    function automatic int cnt_width(input int dwell, input int gap);
        int m;
        m = (dwell > gap) ? dwell : gap;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/hex_lead_zero_finder.sv
// Combinational priority encoder: index of the most-significant non-zero nibble.
// An all-zero word yields index 0. Used only when HEX_SCROLL_LZB_EN is defined.
module hex_lead_zero_finder #(
    parameter int WORD_NIB = 8,
    parameter int IDX_W    = 3
) (
    input  logic [4*WORD_NIB-1:0] word,
    output logic [IDX_W-1:0]      idx
);

    always_comb begin
        idx = '0;
        // Ascending scan so the highest non-zero nibble wins.
        for (int i = 0; i < WORD_NIB; i++) begin
            if (word[4*i +: 4] != 4'h0) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/hex_scroll_sequencer.sv
// Scrolls a multi-nibble word onto a single hex digit, MSB nibble first,
// with a dwell per digit and a blanked gap. Optional macro: HEX_SCROLL_LZB_EN.
module hex_scroll_sequencer
    import hex_scroll_pkg::*;
#(
    parameter int WORD_NIB  = 8,
    parameter int DWELL_CYC = 50000000,
    parameter int GAP_CYC   = 5000000,
    localparam int IDX_W    = idx_width(WORD_NIB),
    localparam int CNT_W    = cnt_width(DWELL_CYC, GAP_CYC)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*WORD_NIB-1:0] i_word,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_abort,
    output logic [3:0]            o_hex,
    output logic                  o_blank,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_state
);

    // Handshake: a word is taken on any rising edge where i_valid && o_ready.
    // o_ready is combinational and drops while i_abort is high.

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t                     state_q, state_d;
    logic [WORD_NIB-1:0][3:0]   word_q, word_d, word_in;
    logic [IDX_W-1:0]           idx_q, idx_d, start_idx;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [3:0]                 hex_q, hex_d;
    logic                       blank_q, blank_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       step;

    assign word_in = i_word;

`ifdef HEX_SCROLL_LZB_EN
    hex_lead_zero_finder #(
        .WORD_NIB (WORD_NIB),
        .IDX_W    (IDX_W)
    ) u_lzf (
        .word (i_word),
        .idx  (start_idx)
    );
`else
    assign start_idx = IDX_W'(WORD_NIB - 1);
`endif

    assign o_ready = (state_q == IDLE) && !i_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            hex_q   <= 4'h0;
            blank_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        blank_d = blank_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        step    = 1'b0;

        case (state_q)
            IDLE: begin
                blank_d = 1'b1;
                busy_d  = 1'b0;
                if (i_valid && o_ready) begin
                    word_d  = word_in;
                    idx_d   = start_idx;
                    cnt_d   = '0;
                    hex_d   = word_in[start_idx];
                    blank_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (GAP_CYC > 0) begin
                        state_d = GAP;
                        blank_d = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    step  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                blank_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Digit finished (after gap, or straight from SHOW when there is no gap).
        if (step) begin
            if (idx_q == '0) begin
                state_d = IDLE;
                blank_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q - IDX_W'(1);
                hex_d   = word_q[idx_d];
                blank_d = 1'b0;
                busy_d  = 1'b1;
                state_d = SHOW;
            end
        end

        if (i_abort) begin
            state_d = IDLE;
            word_d  = word_q;
            idx_d   = '0;
            cnt_d   = '0;
            hex_d   = hex_q;
            blank_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign o_hex   = hex_q;
    assign o_blank = blank_q;
    assign o_idx   = idx_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_hex_scroll_sequencer.sv
// Directed bench for hex_scroll_sequencer: main instance (gap 2) and a no-gap instance.
// Leading-zero checks follow HEX_SCROLL_LZB_EN when the bench is built with it.
module tb_hex_scroll_sequencer;

  localparam int DWELL = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] word_i  [2];
  logic        valid_i [2];
  logic        abort_i [2];
  logic        ready_o [2];
  logic [3:0]  hex_o   [2];
  logic        blank_o [2];
  logic [1:0]  idx_o   [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic [1:0]  state_o [2];

  int errors;
  int checks;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hex_scroll_sequencer #(.WORD_NIB(4), .DWELL_CYC(3), .GAP_CYC(2)) u_main (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_word  (word_i[0]),
    .i_valid (valid_i[0]),
    .o_ready (ready_o[0]),
    .i_abort (abort_i[0]),
    .o_hex   (hex_o[0]),
    .o_blank (blank_o[0]),
    .o_idx   (idx_o[0]),
    .o_busy  (busy_o[0]),
    .o_done  (done_o[0]),
    .o_state (state_o[0])
  );

  hex_scroll_sequencer #(.WORD_NIB(4), .DWELL_CYC(3), .GAP_CYC(0)) u_nogap (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_word  (word_i[1]),
    .i_valid (valid_i[1]),
    .o_ready (ready_o[1]),
    .i_abort (abort_i[1]),
    .o_hex   (hex_o[1]),
    .o_blank (blank_o[1]),
    .o_idx   (idx_o[1]),
    .o_busy  (busy_o[1]),
    .o_done  (done_o[1]),
    .o_state (state_o[1])
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Offer word w at cycle t and check every cycle until the done pulse at t+total+1.
  // With hold set, i_valid stays high carrying w2, which must be taken on the done cycle.
  task automatic run_seq(input int sel, input logic [15:0] w, input int ndig, input int gap,
                         input logic hold, input logic [15:0] w2);
    int period;
    int total;
    int d;
    int ph;
    int idx;
    logic [15:0] cur;
    period = DWELL + gap;
    total  = ndig * period;
    cur    = w;
    exp_q.delete();
    for (int n = ndig - 1; n >= 0; n--) exp_q.push_back(16'(n));
    word_i[sel]  = w;
    valid_i[sel] = 1'b1;
    chk("ready_before_accept", ready_o[sel], 1'b1);
    for (int k = 1; k <= total + 1; k++) begin
      tick();
      if (k <= total) begin
        d   = (k - 1) / period;
        ph  = (k - 1) % period;
        idx = int'(exp_q[d]);
        chk("seq_hex",   hex_o[sel],   cur[4*idx +: 4]);
        chk("seq_blank", blank_o[sel], (ph >= DWELL) ? 1'b1 : 1'b0);
        chk("seq_idx",   idx_o[sel],   idx);
        chk("seq_busy",  busy_o[sel],  1'b1);
        chk("seq_done",  done_o[sel],  1'b0);
        chk("seq_ready", ready_o[sel], 1'b0);
      end else begin
        chk("end_done",  done_o[sel],  1'b1);
        chk("end_ready", ready_o[sel], 1'b1);
        chk("end_blank", blank_o[sel], 1'b1);
        chk("end_busy",  busy_o[sel],  1'b0);
        chk("end_hex",   hex_o[sel],   cur[3:0]);
      end
      if (k == 1) begin
        if (hold) word_i[sel] = w2;
        else      valid_i[sel] = 1'b0;
      end
    end
    if (hold) begin
      tick();
      chk("b2b_hex",   hex_o[sel],   w2[15:12]);
      chk("b2b_blank", blank_o[sel], 1'b0);
      chk("b2b_busy",  busy_o[sel],  1'b1);
      valid_i[sel] = 1'b0;
    end else begin
      tick();
      chk("after_done", done_o[sel], 1'b0);
    end
  endtask

  // ---------------- directed steps ----------------
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      word_i[i]  = 16'h0;
      valid_i[i] = 1'b0;
      abort_i[i] = 1'b0;
    end
    tick();
    tick();
    chk("rst_blank", blank_o[0], 1'b1);
    chk("rst_busy",  busy_o[0],  1'b0);
    chk("rst_hex",   hex_o[0],   4'h0);
    chk("rst_idx",   idx_o[0],   2'd0);
    chk("rst_done",  done_o[0],  1'b0);
    chk("rst_state", state_o[0], 2'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_main",  ready_o[0], 1'b1);
    chk("rst_ready_nogap", ready_o[1], 1'b1);
    tick();

    // Full word with a competing word held on i_valid, taken back-to-back.
    run_seq(0, 16'hA3F0, 4, 2, 1'b1, 16'h5555);

    // Second word accepted at t' (one negedge ago = t'+1); advance to t'+6 (idx 2 SHOW).
    for (int k = 0; k < 5; k++) tick();
    chk("abort_pre_idx",   idx_o[0],   2'd2);
    chk("abort_pre_blank", blank_o[0], 1'b0);
    chk("abort_pre_hex",   hex_o[0],   4'h5);
    abort_i[0] = 1'b1;
    #1;
    chk("abort_ready_low", ready_o[0], 1'b0);
    tick();
    chk("abort_state", state_o[0], 2'd0);
    chk("abort_blank", blank_o[0], 1'b1);
    chk("abort_busy",  busy_o[0],  1'b0);
    chk("abort_idx",   idx_o[0],   2'd0);
    chk("abort_done",  done_o[0],  1'b0);
    abort_i[0] = 1'b0;
    #1;
    chk("abort_ready_back", ready_o[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", done_o[0], 1'b0);
    end

    // Abort together with valid in IDLE must not accept.
    word_i[0]  = 16'h1234;
    valid_i[0] = 1'b1;
    abort_i[0] = 1'b1;
    #1;
    chk("abort_valid_ready", ready_o[0], 1'b0);
    tick();
    chk("abort_valid_busy",  busy_o[0],  1'b0);
    chk("abort_valid_blank", blank_o[0], 1'b1);
    chk("abort_valid_state", state_o[0], 2'd0);
    valid_i[0] = 1'b0;
    abort_i[0] = 1'b0;
    tick();

    // No gap: digits contiguous, done at t+13.
    run_seq(1, 16'h1234, 4, 0, 1'b0, 16'h0);

`ifdef HEX_SCROLL_LZB_EN
    run_seq(0, 16'h00B7, 2, 2, 1'b0, 16'h0);
    run_seq(0, 16'h0000, 1, 2, 1'b0, 16'h0);
`else
    run_seq(0, 16'h00B7, 4, 2, 1'b0, 16'h0);
    run_seq(0, 16'h0000, 4, 2, 1'b0, 16'h0);
`endif

    // Reset asserted mid-SHOW clears everything immediately.
    word_i[0]  = 16'hC5D2;
    valid_i[0] = 1'b1;
    tick();
    valid_i[0] = 1'b0;
    tick();
    chk("midrst_pre_blank", blank_o[0], 1'b0);
    chk("midrst_pre_hex",   hex_o[0],   4'hC);
    rst_n = 1'b0;
    #1;
    chk("midrst_blank", blank_o[0], 1'b1);
    chk("midrst_busy",  busy_o[0],  1'b0);
    chk("midrst_hex",   hex_o[0],   4'h0);
    chk("midrst_idx",   idx_o[0],   2'd0);
    chk("midrst_done",  done_o[0],  1'b0);
    chk("midrst_state", state_o[0], 2'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", ready_o[0], 1'b1);
    tick();
    chk("midrst_idle_busy", busy_o[0], 1'b0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
